sdram_traffic_checker: RTL and testbench
========================================

# sdram_traffic_checker

Parametrised, self-checking traffic source for the SDRAM controller's command/response stream port. It writes an address-derived pattern across a programmable word range, reads the range back with up to MAX_PENDING reads in flight, compares every response, and reports an error count plus the first failing address. It sits in place of the fixed tester in the controller test harness, between a software/host control port and the controller's cmd/rsp streams.

## Interface
- ADDR_WIDTH, 24, word address width of cmd stream
- DATA_WIDTH, 16, data width; multiple of 8
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width
- MAX_PENDING, 8, max reads issued but not yet answered (≥1)
- ERR_WIDTH, 16, error counter width
- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- io_start  in  1  start pulse; sampled only in IDLE
- io_mode  in  2  00 write+verify, 01 write only, 10 verify only, 11 treated as 00
- io_base  in  ADDR_WIDTH  first word address
- io_count  in  ADDR_WIDTH  number of words
- io_seed  in  DATA_WIDTH  pattern seed
- io_busy  out  1  high outside IDLE
- io_done  out  1  one-cycle pulse at end of run
- io_errorCount  out  ERR_WIDTH  saturating mismatch count
- io_firstErrorValid  out  1  a mismatch was recorded this run
- io_firstErrorAddress  out  ADDR_WIDTH  address of first mismatch
- io_cmd_valid / io_cmd_ready  out / in  1  command handshake
- io_cmd_payload_address  out  ADDR_WIDTH
- io_cmd_payload_write  out  1
- io_cmd_payload_data  out  DATA_WIDTH
- io_cmd_payload_mask  out  MASK_WIDTH  always all-ones
- io_rsp_valid / io_rsp_ready  in / out  1  response handshake; rsp_ready constant 1
- io_rsp_payload_data  in  DATA_WIDTH

## Operation
- Word i (0..count-1): address = (base + i) mod 2^ADDR_WIDTH; pattern = seed XOR i truncated/zero-extended to DATA_WIDTH.
- FSM: IDLE → WRITE (mode 00/01) or READ (mode 10) on start; WRITE → READ (mode 00) or DONE (01) after last write accepted; READ → DRAIN after last read accepted; DRAIN → DONE when pending = 0; DONE → IDLE unconditionally.
- io_count = 0: IDLE → DONE, no commands issued.
- Start clears errorCount, firstErrorValid, firstErrorAddress; latches base, count, seed, mode.
- io_start outside IDLE ignored.
- Command index advances only on cmd_valid & cmd_ready; payload stable while valid & !ready.
- READ: cmd_valid deasserted when pending = MAX_PENDING.
- pending: +1 on read accept, −1 on rsp_valid; both same cycle → unchanged.
- Responses arrive in order; expected index counter advances per response; mismatch → errorCount +1 (saturate at all-ones); first mismatch of the run sets firstErrorValid and firstErrorAddress = base + expected index.
- Response with pending = 0 (any state): errorCount +1, first-error fields untouched.

## Timing
- Reset values: io_cmd_valid 0, payload 0, io_busy 0, io_done 0, io_errorCount 0, io_firstErrorValid 0, io_firstErrorAddress 0, io_rsp_ready 1; state IDLE, pending 0.
- Start sampled in cycle t → io_busy and io_cmd_valid high from t+1.
- With cmd_ready constant 1: one command per cycle, no bubble at WRITE→READ transition.
- Compare and counter update registered: visible one cycle after response beat.
- io_done high exactly one cycle, io_busy low in that cycle's successor.
- Reset mid-run: immediate return to reset values; late responses then count as unexpected.

## Structure
- Package sdram_traffic_pkg: FSM state enum (IDLE, WRITE, READ, DRAIN, DONE), mode encodings, pattern function (seed, index, width).
- Sub-module sdram_traffic_scoreboard: pending counter, expected-index counter, comparator, error registers; top holds FSM and command generator.

## Test plan
- Mode 00, base 0x000100, count 4, seed 0xA5A5, ideal SDRAM model → writes 0xA5A5,0xA5A4,0xA5A7,0xA5A6 to 0x100..0x103, 4 reads, done pulse, errorCount 0.
- Same run with model corrupting word at 0x102 → errorCount 1, firstErrorAddress 0x000102, firstErrorValid 1.
- Response latency 20 cycles, MAX_PENDING 8, count 32 → never more than 8 reads outstanding; all 32 checked, errorCount 0.
- cmd_ready toggling random 50%, base 0xFFFFFE, count 4 → addresses 0xFFFFFE,0xFFFFFF,0x000000,0x000001; payload stable during stalls.
- count 0 → io_done pulse at t+2, no cmd_valid; start while busy ignored.
- reset asserted mid-READ with 3 pending → outputs at reset values; 3 late responses → errorCount 3.

Source files
------------

// File: rtl/sdram_traffic_pkg.sv
// rtl/sdram_traffic_pkg.sv - shared types, mode encodings and pattern helper for the SDRAM traffic checker
package sdram_traffic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [1:0] MODE_WRITE_VERIFY = 2'b00;
    localparam logic [1:0] MODE_WRITE_ONLY   = 2'b01;
    localparam logic [1:0] MODE_VERIFY_ONLY  = 2'b10;
    localparam logic [1:0] MODE_ALIAS        = 2'b11;

    // Word pattern: seed XOR index, masked to the stream data width.
    function automatic logic [63:0] pattern_word(input logic [63:0] seed,
                                                 input logic [63:0] index,
                                                 input int width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (seed ^ index) & mask;
    endfunction

endpackage

// File: rtl/sdram_traffic_scoreboard.sv
// rtl/sdram_traffic_scoreboard.sv - read-pending tracking, in-order response compare and error registers
module sdram_traffic_scoreboard
    import sdram_traffic_pkg::*;
#(
    parameter int ADDR_WIDTH  = 24,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_PENDING = 8,
    parameter int ERR_WIDTH   = 16,
    parameter int PEND_WIDTH  = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  read_accept_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic                  rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] rsp_data_i,
    output logic [PEND_WIDTH-1:0] pending_o,
    output logic [PEND_WIDTH-1:0] pending_d_o,
    output logic [ERR_WIDTH-1:0]  error_count_o,
    output logic                  first_err_valid_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    logic [PEND_WIDTH-1:0] pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] exp_idx_q;
    logic [ERR_WIDTH-1:0]  err_q;
    logic                  first_valid_q;
    logic [ADDR_WIDTH-1:0] first_addr_q;
    logic                  rsp_expected, rsp_unexpected, mismatch;
    logic [DATA_WIDTH-1:0] exp_data;

    // A response with nothing outstanding is never matched against the pattern.
    always_comb begin
        rsp_expected   = rsp_valid_i && (pending_q != '0);
        rsp_unexpected = rsp_valid_i && (pending_q == '0);
        exp_data       = DATA_WIDTH'(pattern_word(64'(seed_i), 64'(exp_idx_q), DATA_WIDTH));
        mismatch       = rsp_expected && (rsp_data_i != exp_data);
        pending_d      = pending_q;
        if (read_accept_i && !rsp_expected) begin
            pending_d = pending_q + PEND_WIDTH'(1);
        end else if (!read_accept_i && rsp_expected) begin
            pending_d = pending_q - PEND_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q     <= '0;
            exp_idx_q     <= '0;
            err_q         <= '0;
            first_valid_q <= 1'b0;
            first_addr_q  <= '0;
        end else if (clear_i) begin
            pending_q     <= pending_d;
            exp_idx_q     <= '0;
            err_q         <= '0;
            first_valid_q <= 1'b0;
            first_addr_q  <= '0;
        end else begin
            pending_q <= pending_d;
            if (rsp_expected) begin
                exp_idx_q <= exp_idx_q + ADDR_WIDTH'(1);
            end
            if ((mismatch || rsp_unexpected) && (err_q != '1)) begin
                err_q <= err_q + ERR_WIDTH'(1);
            end
            if (mismatch && !first_valid_q) begin
                first_valid_q <= 1'b1;
                first_addr_q  <= base_i + exp_idx_q;
            end
        end
    end

    assign pending_o         = pending_q;
    assign pending_d_o       = pending_d;
    assign error_count_o     = err_q;
    assign first_err_valid_o = first_valid_q;
    assign first_err_addr_o  = first_addr_q;

endmodule

// File: rtl/sdram_traffic_checker.sv
// rtl/sdram_traffic_checker.sv - run FSM and command generator driving the SDRAM controller cmd/rsp streams
module sdram_traffic_checker
    import sdram_traffic_pkg::*;
#(
    parameter int ADDR_WIDTH  = 24,
    parameter int DATA_WIDTH  = 16,
    parameter int MASK_WIDTH  = DATA_WIDTH / 8,
    parameter int MAX_PENDING = 8,
    parameter int ERR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic [1:0]            io_mode,
    input  logic [ADDR_WIDTH-1:0] io_base,
    input  logic [ADDR_WIDTH-1:0] io_count,
    input  logic [DATA_WIDTH-1:0] io_seed,
    output logic                  io_busy,
    output logic                  io_done,
    output logic [ERR_WIDTH-1:0]  io_errorCount,
    output logic                  io_firstErrorValid,
    output logic [ADDR_WIDTH-1:0] io_firstErrorAddress,
    output logic                  io_cmd_valid,
    input  logic                  io_cmd_ready,
    output logic [ADDR_WIDTH-1:0] io_cmd_payload_address,
    output logic                  io_cmd_payload_write,
    output logic [DATA_WIDTH-1:0] io_cmd_payload_data,
    output logic [MASK_WIDTH-1:0] io_cmd_payload_mask,
    input  logic                  io_rsp_valid,
    output logic                  io_rsp_ready,
    input  logic [DATA_WIDTH-1:0] io_rsp_payload_data
);

    localparam int PEND_WIDTH = $clog2(MAX_PENDING + 1);

    state_e                state_q;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q, count_q, idx_q, idx_next;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  cmd_valid_q, cmd_write_q, done_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_data_q;
    logic                  cmd_fire, read_fire, last_idx, start_ok, room_d;
    logic [PEND_WIDTH-1:0] pending_q, pending_d;

    assign cmd_fire  = cmd_valid_q && io_cmd_ready;
    assign read_fire = cmd_fire && !cmd_write_q;
    assign last_idx  = (idx_q == count_q - ADDR_WIDTH'(1));
    assign idx_next  = idx_q + ADDR_WIDTH'(1);
    assign start_ok  = (state_q == ST_IDLE) && io_start;
    // Throttle on next-cycle occupancy so valid never rises with the window already full.
    assign room_d    = int'(pending_d) < MAX_PENDING;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_WRITE_VERIFY;
            base_q      <= '0;
            count_q     <= '0;
            seed_q      <= '0;
            idx_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (io_start) begin
                    mode_q     <= (io_mode == MODE_ALIAS) ? MODE_WRITE_VERIFY : io_mode;
                    base_q     <= io_base;
                    count_q    <= io_count;
                    seed_q     <= io_seed;
                    idx_q      <= '0;
                    cmd_addr_q <= io_base;
                    if (io_count == '0) begin
                        state_q <= ST_DONE;
                    end else if (io_mode == MODE_VERIFY_ONLY) begin
                        state_q     <= ST_READ;
                        cmd_valid_q <= 1'b1;
                        cmd_write_q <= 1'b0;
                        cmd_data_q  <= '0;
                    end else begin
                        state_q     <= ST_WRITE;
                        cmd_valid_q <= 1'b1;
                        cmd_write_q <= 1'b1;
                        cmd_data_q  <= DATA_WIDTH'(pattern_word(64'(io_seed), 64'd0, DATA_WIDTH));
                    end
                end
                ST_WRITE: if (cmd_fire) begin
                    if (last_idx) begin
                        idx_q       <= '0;
                        cmd_addr_q  <= base_q;
                        cmd_data_q  <= '0;
                        cmd_write_q <= 1'b0;
                        if (mode_q == MODE_WRITE_ONLY) begin
                            state_q     <= ST_DONE;
                            cmd_valid_q <= 1'b0;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end else begin
                        idx_q      <= idx_next;
                        cmd_addr_q <= base_q + idx_next;
                        cmd_data_q <= DATA_WIDTH'(pattern_word(64'(seed_q), 64'(idx_next), DATA_WIDTH));
                    end
                end
                ST_READ: begin
                    if (cmd_fire && last_idx) begin
                        state_q     <= ST_DRAIN;
                        cmd_valid_q <= 1'b0;
                    end else begin
                        if (cmd_fire) begin
                            idx_q      <= idx_next;
                            cmd_addr_q <= base_q + idx_next;
                        end
                        cmd_valid_q <= room_d;
                    end
                end
                ST_DRAIN: if (pending_q == '0) begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sdram_traffic_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_PENDING(MAX_PENDING),
        .ERR_WIDTH  (ERR_WIDTH),
        .PEND_WIDTH (PEND_WIDTH)
    ) u_scoreboard (
        .clk              (clk),
        .reset            (reset),
        .clear_i          (start_ok),
        .read_accept_i    (read_fire),
        .base_i           (base_q),
        .seed_i           (seed_q),
        .rsp_valid_i      (io_rsp_valid),
        .rsp_data_i       (io_rsp_payload_data),
        .pending_o        (pending_q),
        .pending_d_o      (pending_d),
        .error_count_o    (io_errorCount),
        .first_err_valid_o(io_firstErrorValid),
        .first_err_addr_o (io_firstErrorAddress)
    );

    assign io_busy                = (state_q != ST_IDLE);
    assign io_done                = done_q;
    assign io_cmd_valid           = cmd_valid_q;
    assign io_cmd_payload_address = cmd_addr_q;
    assign io_cmd_payload_write   = cmd_write_q;
    assign io_cmd_payload_data    = cmd_data_q;
    assign io_cmd_payload_mask    = '1;
    assign io_rsp_ready           = 1'b1;

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// tb/tb_sdram_traffic_checker.sv - directed self-checking bench with a behavioural SDRAM stream model
module tb_sdram_traffic_checker;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int MW = 2;
    localparam int MP = 8;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          io_start = 1'b0;
    logic [1:0]    io_mode = 2'b00;
    logic [AW-1:0] io_base = '0;
    logic [AW-1:0] io_count = '0;
    logic [DW-1:0] io_seed = '0;
    logic          io_busy, io_done, io_firstErrorValid;
    logic [EW-1:0] io_errorCount;
    logic [AW-1:0] io_firstErrorAddress;
    logic          io_cmd_valid, io_cmd_ready, io_cmd_payload_write;
    logic [AW-1:0] io_cmd_payload_address;
    logic [DW-1:0] io_cmd_payload_data;
    logic [MW-1:0] io_cmd_payload_mask;
    logic          io_rsp_valid, io_rsp_ready;
    logic [DW-1:0] io_rsp_payload_data;

    always #5 clk = ~clk;

    sdram_traffic_checker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .MAX_PENDING(MP), .ERR_WIDTH(EW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .io_start              (io_start),
        .io_mode               (io_mode),
        .io_base               (io_base),
        .io_count              (io_count),
        .io_seed               (io_seed),
        .io_busy               (io_busy),
        .io_done               (io_done),
        .io_errorCount         (io_errorCount),
        .io_firstErrorValid    (io_firstErrorValid),
        .io_firstErrorAddress  (io_firstErrorAddress),
        .io_cmd_valid          (io_cmd_valid),
        .io_cmd_ready          (io_cmd_ready),
        .io_cmd_payload_address(io_cmd_payload_address),
        .io_cmd_payload_write  (io_cmd_payload_write),
        .io_cmd_payload_data   (io_cmd_payload_data),
        .io_cmd_payload_mask   (io_cmd_payload_mask),
        .io_rsp_valid          (io_rsp_valid),
        .io_rsp_ready          (io_rsp_ready),
        .io_rsp_payload_data   (io_rsp_payload_data)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] mem [logic [AW-1:0]];
    rsp_t          rq[$];
    logic [AW-1:0] log_addr[$];
    logic          log_wr[$];
    logic [DW-1:0] log_data[$];
    int            log_cyc[$];
    int            cyc = 0, lat = 1, ready_mode = 0, read_limit = 0, reads_fired = 0;
    int            outstanding = 0, max_out = 0, rsp_count = 0, stalls = 0, stall_viol = 0;
    bit            corrupt_en = 0;
    logic [AW-1:0] corrupt_addr = '0;
    logic [15:0]   rdy_pat = 16'b1011_0010_1101_0100;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic          p_wr;

    initial begin
        logic [DW-1:0] d;
        io_cmd_ready = 1'b0;
        io_rsp_valid = 1'b0;
        io_rsp_payload_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                stalls++;
                if (!io_cmd_valid || io_cmd_payload_address !== p_addr ||
                    io_cmd_payload_data !== p_data || io_cmd_payload_write !== p_wr)
                    stall_viol++;
            end
            case (ready_mode)
                0:       io_cmd_ready = 1'b1;
                1:       io_cmd_ready = rdy_pat[cyc % 16];
                default: io_cmd_ready = (reads_fired < read_limit);
            endcase
            prev_stall = io_cmd_valid && !io_cmd_ready;
            p_addr = io_cmd_payload_address;
            p_data = io_cmd_payload_data;
            p_wr   = io_cmd_payload_write;
            if (io_cmd_valid && io_cmd_ready) begin
                log_addr.push_back(io_cmd_payload_address);
                log_wr.push_back(io_cmd_payload_write);
                log_data.push_back(io_cmd_payload_data);
                log_cyc.push_back(cyc);
                if (io_cmd_payload_write) begin
                    mem[io_cmd_payload_address] = io_cmd_payload_data;
                end else begin
                    reads_fired++;
                    d = mem.exists(io_cmd_payload_address) ? mem[io_cmd_payload_address] : '0;
                    if (corrupt_en && io_cmd_payload_address == corrupt_addr) d = d ^ 16'h0001;
                    rq.push_back('{cyc + lat, d});
                    outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                end
            end
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                io_rsp_valid = 1'b1;
                io_rsp_payload_data = rq[0].data;
                void'(rq.pop_front());
                outstanding--;
                rsp_count++;
            end else begin
                io_rsp_valid = 1'b0;
            end
        end
    end

    task automatic clear_model();
        log_addr.delete(); log_wr.delete(); log_data.delete(); log_cyc.delete();
        reads_fired = 0; rsp_count = 0; max_out = 0; stalls = 0; stall_viol = 0;
    endtask

    task automatic run(input logic [1:0] mode, input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                       input logic [DW-1:0] seed, input int budget, input string tag);
        int n;
        clear_model();
        @(negedge clk);
        io_mode = mode; io_base = base; io_count = cnt; io_seed = seed; io_start = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        check({tag, "_busy_after_start"}, io_busy, 1);
        check({tag, "_valid_after_start"}, io_cmd_valid, 1);
        n = 0;
        while (!io_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, io_done, 1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, io_done, 0);
        check({tag, "_idle_after_done"}, io_busy, 0);
    endtask

    initial begin
        logic [DW-1:0] t1_data [4];
        logic [AW-1:0] t4_addr [4];
        int n;
        t1_data = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
        t4_addr = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};

        repeat (3) @(negedge clk);
        check("rst_cmd_valid", io_cmd_valid, 0);
        check("rst_busy", io_busy, 0);
        check("rst_done", io_done, 0);
        check("rst_err", io_errorCount, 0);
        check("rst_fev", io_firstErrorValid, 0);
        check("rst_rsp_ready", io_rsp_ready, 1);
        check("rst_addr", io_cmd_payload_address, 0);
        reset = 1'b1;
        @(negedge clk);

        // write+verify, ideal memory
        lat = 1; ready_mode = 0; corrupt_en = 0;
        run(2'b00, 24'h000100, 24'd4, 16'hA5A5, 200, "t1");
        check("t1_cmd_count", log_addr.size(), 8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_w%0d_addr", i), log_addr[i], 24'h000100 + i);
            check($sformatf("t1_w%0d_wr", i), log_wr[i], 1);
            check($sformatf("t1_w%0d_data", i), log_data[i], t1_data[i]);
            check($sformatf("t1_r%0d_addr", i), log_addr[4+i], 24'h000100 + i);
            check($sformatf("t1_r%0d_wr", i), log_wr[4+i], 0);
        end
        check("t1_no_bubble", log_cyc[7] - log_cyc[0], 7);
        check("t1_rsp_count", rsp_count, 4);
        check("t1_err", io_errorCount, 0);
        check("t1_fev", io_firstErrorValid, 0);
        check("t1_mask", io_cmd_payload_mask, 2'b11);

        // same run, memory corrupts word 0x102
        corrupt_en = 1; corrupt_addr = 24'h000102;
        run(2'b00, 24'h000100, 24'd4, 16'hA5A5, 200, "t2");
        check("t2_err", io_errorCount, 1);
        check("t2_fev", io_firstErrorValid, 1);
        check("t2_fea", io_firstErrorAddress, 24'h000102);
        corrupt_en = 0;

        // long latency: read window must saturate at MAX_PENDING
        lat = 20;
        run(2'b00, 24'h001000, 24'd32, 16'h0F0F, 1000, "t3");
        check("t3_rsp_count", rsp_count, 32);
        check("t3_max_outstanding", max_out, 8);
        check("t3_err_cleared", io_errorCount, 0);
        check("t3_fev", io_firstErrorValid, 0);

        // address wrap with stalling cmd_ready, mode 11 behaves as 00
        lat = 3; ready_mode = 1;
        run(2'b11, 24'hFFFFFE, 24'd4, 16'h1234, 400, "t4");
        check("t4_cmd_count", log_addr.size(), 8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_w%0d_addr", i), log_addr[i], t4_addr[i]);
            check($sformatf("t4_w%0d_data", i), log_data[i], 16'h1234 ^ i);
            check($sformatf("t4_r%0d_addr", i), log_addr[4+i], t4_addr[i]);
        end
        check("t4_stalls_seen", stalls > 0, 1);
        check("t4_stall_stable", stall_viol, 0);
        check("t4_err", io_errorCount, 0);
        ready_mode = 0;

        // count 0: done at t+2 with no commands; start during DONE ignored
        clear_model();
        @(negedge clk);
        io_mode = 2'b00; io_base = 24'h000300; io_count = '0; io_start = 1'b1;
        @(negedge clk);
        check("t5_busy_t1", io_busy, 1);
        check("t5_done_t1", io_done, 0);
        check("t5_valid_t1", io_cmd_valid, 0);
        io_mode = 2'b01; io_count = 24'd5;
        @(negedge clk);
        io_start = 1'b0;
        check("t5_done_t2", io_done, 1);
        check("t5_busy_t2", io_busy, 0);
        repeat (6) @(negedge clk);
        check("t5_no_cmds", log_addr.size(), 0);
        check("t5_stay_idle", io_busy, 0);

        // reset in READ with 3 reads outstanding, then late responses
        clear_model();
        lat = 40; ready_mode = 2; read_limit = 3;
        @(negedge clk);
        io_mode = 2'b10; io_base = 24'h000200; io_count = 24'd8; io_start = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        n = 0;
        while (reads_fired < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_three_reads", reads_fired, 3);
        repeat (2) @(negedge clk);
        check("t6_busy_before", io_busy, 1);
        check("t6_valid_before", io_cmd_valid, 1);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", io_cmd_valid, 0);
        check("t6_rst_busy", io_busy, 0);
        check("t6_rst_addr", io_cmd_payload_address, 0);
        check("t6_rst_err", io_errorCount, 0);
        check("t6_rst_rsp_ready", io_rsp_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (rsp_count < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_late_rsp_count", rsp_count, 3);
        repeat (3) @(negedge clk);
        check("t6_late_err", io_errorCount, 3);
        check("t6_late_fev", io_firstErrorValid, 0);
        check("t6_late_busy", io_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
